// File: rtl/comb_sweep_harness_pkg.sv
// Shared types, default MISR constants and the MISR step function for the
// exhaustive-sweep harness.
package comb_sweep_harness_pkg;

  typedef enum logic [1:0] {IDLE, APPLY, EMIT, DONE} state_e;

  localparam int          MISR_MAX_W = 64;
  localparam logic [15:0] DEF_POLY   = 16'h1021;
  localparam logic [15:0] DEF_SEED   = 16'hFFFF;

  // One MISR shift: left shift, conditional polynomial feedback from the MSB,
  // then fold in the response word. Operates on the low 'width' bits.
  function automatic logic [MISR_MAX_W-1:0] misr_step(
    input logic [MISR_MAX_W-1:0] sig,
    input logic [MISR_MAX_W-1:0] poly,
    input logic [MISR_MAX_W-1:0] din,
    input int unsigned           width
  );
    logic [MISR_MAX_W-1:0] mask;
    logic                  msb;
    mask = {MISR_MAX_W{1'b1}} >> (MISR_MAX_W - width);
    msb  = |(sig & (MISR_MAX_W'(1) << (width - 1)));
    return ((sig << 1) ^ (msb ? poly : '0) ^ din) & mask;
  endfunction

endpackage

// File: rtl/comb_sweep_harness_if.sv
// Truth-table row stream: one row per swept input vector, valid/ready handshake.
interface comb_sweep_harness_if #(
  parameter int N_IN  = 7,
  parameter int N_OUT = 5
) ();

  logic             tt_valid;
  logic             tt_ready;
  logic [N_IN-1:0]  tt_addr;
  logic [N_OUT-1:0] tt_data;

  modport master (output tt_valid, output tt_addr, output tt_data, input tt_ready);
  modport slave  (input tt_valid, input tt_addr, input tt_data, output tt_ready);

endinterface

// File: rtl/comb_sweep_harness_misr_reg.sv
// Signature register: seeds on reset or on request, folds one response word
// per step.
module comb_sweep_harness_misr_reg
  import comb_sweep_harness_pkg::*;
#(
  parameter int               MISR_W = 16,
  parameter int               N_OUT  = 5,
  parameter logic [MISR_W-1:0] POLY  = DEF_POLY,
  parameter logic [MISR_W-1:0] SEED  = DEF_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_seed,
  input  logic              step,
  input  logic [N_OUT-1:0]  f_i,
  output logic [MISR_W-1:0] sig
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= SEED;
    end else if (load_seed) begin
      sig <= SEED;
    end else if (step) begin
      sig <= MISR_W'(misr_step(MISR_MAX_W'(sig), MISR_MAX_W'(POLY),
                               MISR_MAX_W'(f_i), MISR_W));
    end
  end

endmodule

// File: rtl/comb_sweep_harness.sv
// Drives every input vector of a combinational netlist in order, streams each
// sampled response as a truth-table row and compacts all rows into a MISR.
module comb_sweep_harness
  import comb_sweep_harness_pkg::*;
#(
  parameter int                N_IN   = 7,
  parameter int                N_OUT  = 5,
  parameter int                SETTLE = 1,
  parameter int                MISR_W = 16,
  parameter logic [MISR_W-1:0] POLY   = DEF_POLY,
  parameter logic [MISR_W-1:0] SEED   = DEF_SEED
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic [N_IN-1:0]      x_o,
  input  logic [N_OUT-1:0]     f_i,
  comb_sweep_harness_if.master tt,
  output logic                 busy,
  output logic                 done,
  output logic [MISR_W-1:0]    signature
);

  localparam int            CNT_W    = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  // One extra bit so the last-vector compare never aliases to vector 0.
  localparam logic [N_IN:0] LAST_VEC = {1'b0, {N_IN{1'b1}}};

  state_e           state_q, state_d;
  logic [N_IN:0]    vec_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N_IN-1:0]  addr_p0;
  logic [N_OUT-1:0] data_p0;
  logic             vld_p0;
  logic             load_seed, sample, vec_clr, vec_inc, cnt_clr, cnt_inc;
  logic             settle_hit, last_vec;

  assign settle_hit = (cnt_q == CNT_W'(SETTLE));
  assign last_vec   = (vec_q == LAST_VEC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load_seed = 1'b0;
    sample    = 1'b0;
    vec_clr   = 1'b0;
    vec_inc   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d   = APPLY;
          load_seed = 1'b1;
          vec_clr   = 1'b1;
          cnt_clr   = 1'b1;
        end
      end
      APPLY: begin
        if (abort) begin
          state_d = IDLE;
          vec_clr = 1'b1;
          cnt_clr = 1'b1;
        end else if (settle_hit) begin
          state_d = EMIT;
          sample  = 1'b1;
          cnt_clr = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      EMIT: begin
        if (abort) begin
          state_d = IDLE;
          vec_clr = 1'b1;
          cnt_clr = 1'b1;
        end else if (tt.tt_ready) begin
          if (last_vec) begin
            state_d = DONE;
          end else begin
            state_d = APPLY;
            vec_inc = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: vector/settle counters and the captured truth-table row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q   <= '0;
      cnt_q   <= '0;
      addr_p0 <= '0;
      data_p0 <= '0;
    end else begin
      if (vec_clr)      vec_q <= '0;
      else if (vec_inc) vec_q <= vec_q + (N_IN + 1)'(1);
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + CNT_W'(1);
      if (sample) begin
        addr_p0 <= vec_q[N_IN-1:0];
        data_p0 <= f_i;
      end
    end
  end

  assign vld_p0      = (state_q == EMIT);
  assign x_o         = vec_q[N_IN-1:0];
  assign busy        = (state_q == APPLY) || (state_q == EMIT);
  assign done        = (state_q == DONE);
  assign tt.tt_valid = vld_p0;
  assign tt.tt_addr  = addr_p0;
  assign tt.tt_data  = data_p0;

  comb_sweep_harness_misr_reg #(
    .MISR_W (MISR_W),
    .N_OUT  (N_OUT),
    .POLY   (POLY),
    .SEED   (SEED)
  ) u_misr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_seed (load_seed),
    .step      (sample),
    .f_i       (f_i),
    .sig       (signature)
  );

endmodule

// File: tb/tb_comb_sweep_harness.sv
// Scoreboard bench: three harness instances (defaults, 1-input zero-seed,
// zero-settle) with a bench-side netlist model and MISR model.
module tb_comb_sweep_harness;

  typedef struct packed {
    logic [6:0] addr;
    logic [4:0] data;
  } row_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;
  int done_cnt_c = 0;
  row_t qa[$];
  row_t qb[$];

  // Instance A: default parameters, netlist model f = x[4:0]
  logic        start_a = 1'b0, abort_a = 1'b0, rdy_a = 1'b1;
  logic [6:0]  x_a;
  logic [4:0]  f_a;
  logic        busy_a, done_a;
  logic [15:0] sig_a;
  comb_sweep_harness_if #(.N_IN(7), .N_OUT(5)) ifa ();
  assign ifa.tt_ready = rdy_a;
  assign f_a = x_a[4:0];
  comb_sweep_harness dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .x_o(x_a),
    .f_i(f_a), .tt(ifa), .busy(busy_a), .done(done_a), .signature(sig_a)
  );

  // Instance B: one input, zero seed, constant response 5'b00001
  logic        start_b = 1'b0, abort_b = 1'b0, rdy_b = 1'b1;
  logic [0:0]  x_b;
  logic [4:0]  f_b;
  logic        busy_b, done_b;
  logic [15:0] sig_b;
  comb_sweep_harness_if #(.N_IN(1), .N_OUT(5)) ifb ();
  assign ifb.tt_ready = rdy_b;
  assign f_b = 5'b00001;
  comb_sweep_harness #(.N_IN(1), .SEED(16'h0000)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .x_o(x_b),
    .f_i(f_b), .tt(ifb), .busy(busy_b), .done(done_b), .signature(sig_b)
  );

  // Instance C: SETTLE = 0
  logic        start_c = 1'b0, abort_c = 1'b0, rdy_c = 1'b1;
  logic [6:0]  x_c;
  logic [4:0]  f_c;
  logic        busy_c, done_c;
  logic [15:0] sig_c;
  comb_sweep_harness_if #(.N_IN(7), .N_OUT(5)) ifc ();
  assign ifc.tt_ready = rdy_c;
  assign f_c = x_c[4:0];
  comb_sweep_harness #(.SETTLE(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .abort(abort_c), .x_o(x_c),
    .f_i(f_c), .tt(ifc), .busy(busy_c), .done(done_c), .signature(sig_c)
  );

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic logic [15:0] misr_model(input logic [15:0] s, input logic [4:0] d);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {11'b0, d};
  endfunction

  function automatic logic [15:0] sweep_sig(input logic [15:0] seed, input int nvec);
    logic [15:0] s;
    s = seed;
    for (int v = 0; v < nvec; v++) s = misr_model(s, 5'(v));
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input int n);
    row_t r;
    for (int v = 0; v < n; v++) begin
      r.addr = 7'(v);
      r.data = 5'(v);
      qa.push_back(r);
    end
  endtask

  task automatic start_a_sweep(output int first_cyc);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("a_busy_after_start", busy_a, 1);
    first_cyc = int'(cyc);
  endtask

  task automatic wait_apply_a(input logic [6:0] v);
    int n = 0;
    while (!(busy_a && !ifa.tt_valid && x_a == v) && n < 2000) begin
      tick();
      n++;
    end
    check("a_apply_wait", busy_a && !ifa.tt_valid && x_a == v, 1);
  endtask

  task automatic wait_done_a(output int at_cyc);
    int n = 0;
    while (!done_a && n < 2000) begin
      tick();
      n++;
    end
    check("a_done_wait", done_a, 1);
    at_cyc = int'(cyc);
  endtask

  // Monitor: pops the expected row on every accepted handshake
  always @(negedge clk) begin
    row_t ea, eb;
    if (rst_n && ifa.tt_valid && ifa.tt_ready) begin
      if (qa.size() == 0) check("a_row_extra", qa.size(), 1);
      else begin
        ea = qa.pop_front();
        check("a_row_addr", ifa.tt_addr, ea.addr);
        check("a_row_data", ifa.tt_data, ea.data);
      end
    end
    if (rst_n && ifb.tt_valid && ifb.tt_ready) begin
      if (qb.size() == 0) check("b_row_extra", qb.size(), 1);
      else begin
        eb = qb.pop_front();
        check("b_row_addr", ifb.tt_addr, eb.addr);
        check("b_row_data", ifb.tt_data, eb.data);
      end
    end
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
    if (done_c) done_cnt_c++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, %0d/%0d passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, n;
    logic [15:0] full_sig, part_sig;
    row_t r;
    full_sig = sweep_sig(16'hFFFF, 128);
    part_sig = sweep_sig(16'hFFFF, 20);

    repeat (3) tick();
    check("rst_x_o", x_a, 0);
    check("rst_tt_valid", ifa.tt_valid, 0);
    check("rst_tt_addr", ifa.tt_addr, 0);
    check("rst_tt_data", ifa.tt_data, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_signature", sig_a, 16'hFFFF);
    check("rst_signature_b", sig_b, 16'h0000);
    rst_n = 1'b1;
    repeat (2) tick();

    // Abort beats start in IDLE
    start_a = 1'b1; abort_a = 1'b1;
    tick();
    start_a = 1'b0; abort_a = 1'b0;
    check("idle_abort_prio_busy", busy_a, 0);

    // Reset in the middle of a sweep
    push_a(37);
    start_a_sweep(t0);
    wait_apply_a(7'd37);
    rst_n = 1'b0;
    #1;
    check("midrst_x_o", x_a, 0);
    check("midrst_tt_valid", ifa.tt_valid, 0);
    check("midrst_busy", busy_a, 0);
    check("midrst_signature", sig_a, 16'hFFFF);
    check("midrst_done", done_a, 0);
    check("midrst_rows_left", qa.size(), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("midrst_stay_idle", busy_a, 0);
    check("midrst_no_done", done_cnt_a, 0);

    // Full sweep, ready tied high
    push_a(128);
    start_a_sweep(t0);
    check("full_first_x", x_a, 0);
    wait_done_a(t1);
    check("full_cycles", t1 - t0, 384);
    check("full_done_busy", busy_a, 0);
    check("full_signature", sig_a, full_sig);
    check("full_rows_left", qa.size(), 0);
    tick();
    check("full_done_one_cycle", done_a, 0);
    check("full_done_count", done_cnt_a, 1);
    repeat (3) tick();
    check("full_sig_hold", sig_a, full_sig);

    // Backpressure at row 5 plus ignored starts
    push_a(128);
    start_a_sweep(t0);
    wait_apply_a(7'd5);
    rdy_a = 1'b0;
    n = 0;
    while (!ifa.tt_valid && n < 20) begin tick(); n++; end
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", ifa.tt_valid, 1);
      check("bp_addr", ifa.tt_addr, 5);
      check("bp_data", ifa.tt_data, 5);
      check("bp_x_o", x_a, 5);
      tick();
    end
    rdy_a = 1'b1;
    wait_apply_a(7'd50);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("busy_start_ignored_busy", busy_a, 1);
    check("busy_start_ignored_x", x_a, 50);
    wait_done_a(t1);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("done_start_ignored", busy_a, 0);
    repeat (3) tick();
    check("done_start_still_idle", busy_a, 0);
    check("bp_done_count", done_cnt_a, 2);
    check("bp_rows_left", qa.size(), 0);
    check("bp_signature", sig_a, full_sig);

    // Abort during APPLY of vector 20, then restart
    push_a(20);
    start_a_sweep(t0);
    wait_apply_a(7'd20);
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    check("abort_busy", busy_a, 0);
    check("abort_x_o", x_a, 0);
    check("abort_tt_valid", ifa.tt_valid, 0);
    check("abort_done", done_a, 0);
    check("abort_signature", sig_a, part_sig);
    check("abort_rows_left", qa.size(), 0);
    repeat (5) tick();
    check("abort_sig_hold", sig_a, part_sig);
    check("abort_no_done", done_cnt_a, 2);
    push_a(128);
    start_a_sweep(t0);
    check("restart_seed", sig_a, 16'hFFFF);
    check("restart_x_o", x_a, 0);
    wait_done_a(t1);
    check("restart_signature", sig_a, full_sig);
    tick();
    check("restart_done_count", done_cnt_a, 3);

    // One-input sweep, zero seed, constant response
    r.addr = 7'd0; r.data = 5'b00001; qb.push_back(r);
    r.addr = 7'd1; r.data = 5'b00001; qb.push_back(r);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    n = 0;
    while (!done_b && n < 100) begin tick(); n++; end
    check("b_done_wait", done_b, 1);
    check("b_signature", sig_b, 16'h0003);
    check("b_rows_left", qb.size(), 0);

    // Zero-settle sweep timing
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    check("c_busy_after_start", busy_c, 1);
    t0 = int'(cyc);
    n = 0;
    while (!done_c && n < 2000) begin tick(); n++; end
    check("c_done_wait", done_c, 1);
    check("c_cycles", int'(cyc) - t0, 256);
    check("c_signature", sig_c, full_sig);
    tick();
    check("c_done_count", done_cnt_c, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
